alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 130 +++++++++++++
 tb/tb_alu_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequences one command at a time through an external combinational ALU.
// Operands are held on alu_* for SETTLE cycles, the result is captured, then
// presented on a valid/ready response port. Opcode 3'b111 is rejected with rsp_err.
// Optional feature: define ALU_SEQ_CNT_EN to enable the accepted-command counter
// (cmd_count); when undefined, cmd_count is tied to zero.
module alu_seq #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [2:0]  rsp_op,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] cmd_count
);

  localparam int unsigned DW = 16;
  localparam int unsigned OW = 3;
  localparam int unsigned CW = 4;
  localparam logic [OW-1:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] settle_cnt;
  logic          accept;

  // cmd_ready is a registered flag that is high exactly when state is IDLE
  assign accept = cmd_valid && cmd_ready;

  // Command sequencer: accept, hold operands, capture result, hand off response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      settle_cnt <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            if (cmd_op == OP_ILLEGAL) begin
              // Illegal opcode bypasses the ALU entirely; alu_* keep their values
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_op    <= cmd_op;
              rsp_err   <= 1'b1;
              state     <= RESP;
            end else begin
              alu_a      <= cmd_a;
              alu_b      <= cmd_b;
              alu_op     <= cmd_op;
              settle_cnt <= CW'(SETTLE - 1);
              state      <= DRIVE;
            end
          end
        end
        DRIVE: begin
          if (settle_cnt == '0) begin
            state <= CAPTURE;
          end else begin
            settle_cnt <= settle_cnt - CW'(1);
          end
        end
        CAPTURE: begin
          rsp_data  <= DW'(alu_out);
          rsp_op    <= alu_op;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_CNT_EN
  logic [DW-1:0] cmd_cnt;

  // Count every accepted command, illegal ones included; wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_cnt <= '0;
    end else if (accept) begin
      cmd_cnt <= cmd_cnt + DW'(1);
    end
  end

  assign cmd_count = cmd_cnt;
`else
  assign cmd_count = '0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with an XOR ALU stub (SETTLE=1).
// Works with ALU_SEQ_CNT_EN defined or undefined.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic [2:0]  cmd_op = '0;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_op;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_op;
  logic        rsp_err;
  logic        busy;
  logic [15:0] cmd_count;
  logic [15:0] noise = '0;

  int total = 0;
  int bad = 0;

  alu_seq #(.SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .busy(busy), .cmd_count(cmd_count)
  );

  // XOR ALU stub; noise lets the bench disturb alu_out outside CAPTURE
  assign alu_out = alu_a ^ alu_b ^ noise;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: present a command, wait for its acceptance, then count
  // cycles (accepting cycle = 0) until rsp_valid is seen.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       output int lat);
    int n;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("accept_timeout", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int seen;

    // Asynchronous reset: outputs clear without a clock edge
    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs",
          {alu_a, alu_b, alu_op, rsp_data, rsp_op, rsp_err, rsp_valid, busy},
          64'd0);
    check("reset_count", 64'(cmd_count), 64'd0);
    check("reset_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'({cmd_ready, busy}), 64'b10);

    // Basic: 20 ^ 21 = 1, response in cycle 3
    rsp_ready = 1'b1;
    issue(16'd20, 16'd21, 3'b000, lat);
    check("basic_latency", 64'(lat), 64'd3);
    check("basic_data", 64'(rsp_data), 64'h0001);
    check("basic_op_err", 64'({rsp_op, rsp_err}), 64'b0000);
    check("basic_alu_drive", {alu_a, alu_b, alu_op}, {16'd20, 16'd21, 3'b000});
    check("basic_busy", 64'({cmd_ready, busy}), 64'b01);
    @(negedge clk);
    check("basic_idle", 64'({cmd_ready, busy, rsp_valid}), 64'b100);

    // Backpressure: 51 ^ 59 = 8 held while rsp_ready is low; stray command ignored
    rsp_ready = 1'b0;
    issue(16'd51, 16'd59, 3'b100, lat);
    check("bp_latency", 64'(lat), 64'd3);
    noise = 16'hA5A5;
    cmd_a = 16'd7; cmd_b = 16'd9; cmd_op = 3'b001; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {rsp_valid, cmd_ready, rsp_data, rsp_op, rsp_err},
            {1'b1, 1'b0, 16'h0008, 3'b100, 1'b0});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    noise = '0;
    check("bp_release", 64'({cmd_ready, busy, rsp_valid}), 64'b100);
    check("bp_alu_kept", {alu_a, alu_b, alu_op}, {16'd51, 16'd59, 3'b100});

    // Illegal opcode: response next cycle, ALU untouched
    rsp_ready = 1'b0;
    issue(16'd21, 16'd21, 3'b111, lat);
    check("ill_latency", 64'(lat), 64'd1);
    check("ill_rsp", {rsp_data, rsp_op, rsp_err}, {16'h0000, 3'b111, 1'b1});
    check("ill_alu_kept", {alu_a, alu_b, alu_op}, {16'd51, 16'd59, 3'b100});
    rsp_ready = 1'b1;
    @(negedge clk);
    check("ill_idle", 64'({cmd_ready, rsp_valid}), 64'b10);

    // Reset while in DRIVE: everything clears immediately, no response follows
    cmd_a = 16'd3; cmd_b = 16'd5; cmd_op = 3'b001; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("midop_drive", {busy, alu_a, alu_b}, {1'b1, 16'd3, 16'd5});
    #2 rst_n = 1'b0;
    #1;
    check("midop_reset_outputs",
          {alu_a, alu_b, alu_op, rsp_data, rsp_op, rsp_err, rsp_valid, busy},
          64'd0);
    check("midop_reset_count", 64'(cmd_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midop_ready", 64'({cmd_ready, busy}), 64'b10);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    check("midop_no_rsp", 64'(seen), 64'd0);

    // Counter: seven commands, ops 000..110
    for (int i = 0; i < 7; i++) begin
      issue(16'h0100 + 16'(i), 16'h00F0, 3'(i), lat);
      check("cnt_latency", 64'(lat), 64'd3);
      check("cnt_rsp", {rsp_data, rsp_op, rsp_err},
            {16'h01F0 + 16'(i), 3'(i), 1'b0});
      @(negedge clk);
    end
`ifdef ALU_SEQ_CNT_EN
    check("cnt_seven", 64'(cmd_count), 64'd7);
    force dut.cmd_cnt = 16'hFFFF;
    #1;
    release dut.cmd_cnt;
    check("cnt_preload", 64'(cmd_count), 64'hFFFF);
    @(negedge clk);
    issue(16'd1, 16'd2, 3'b010, lat);
    check("cnt_wrap", 64'(cmd_count), 64'h0000);
`else
    check("cnt_seven", 64'(cmd_count), 64'd0);
    issue(16'd1, 16'd2, 3'b010, lat);
    check("cnt_tied", 64'(cmd_count), 64'h0000);
`endif
    check("final_rsp", 64'(rsp_data), 64'h0003);
    @(negedge clk);
    check("final_idle", 64'({cmd_ready, busy, rsp_valid}), 64'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
